issue_ctrl: RTL

- Decode-to-execute issue controller that sits directly behind the instruction decoder.
- Registers decoded fields into an issue register and blocks issue on load-use and WAW hazards using a 32-entry pending-load scoreboard.
- Holds issue after a control-transfer instruction until execute resolves it.
- Traps on illegal encodings (code == 12'hFFF).

---
 rtl/issue_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/issue_ctrl.sv
// issue_ctrl: decode-to-execute issue register with pending-load scoreboard, branch hold and illegal-op trap
module issue_ctrl #(
  parameter int          STALL_CNT_W = 16,
  parameter logic [11:0] ILL_CODE    = 12'hFFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rs1i,
  input  logic [4:0]             in_rs2i,
  input  logic [4:0]             in_rdi,
  input  logic [31:0]            in_imm,
  input  logic [11:0]            in_code,
  input  logic                   in_isLoad,
  input  logic                   in_isBranch,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4:0]             out_rs1i,
  output logic [4:0]             out_rs2i,
  output logic [4:0]             out_rdi,
  output logic [31:0]            out_imm,
  output logic [11:0]            out_code,
  output logic                   out_isLoad,
  output logic                   out_isBranch,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_rdi,
  input  logic                   br_resolve,
  input  logic                   flush,
  output logic                   trap,
  input  logic                   trap_clr,
  output logic [31:0]            busy_vec,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, BR_WAIT, TRAP} state_t;
  state_t state_q, state_d;
  logic [31:0] busy_q, busy_d, busy_eff;
  logic [60:0] fields_q, fields_d;
  logic out_valid_q, out_valid_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic hazard, take, ill, acc;
  always_comb begin
    busy_eff = busy_q & ~(wb_valid ? 32'd1 << wb_rdi : 32'd0);
    hazard = in_valid & ((busy_eff[in_rs1i] & |in_rs1i) | (busy_eff[in_rs2i] & |in_rs2i) | (busy_eff[in_rdi] & |in_rdi));
    in_ready = !rst & state_q == RUN & !hazard & (!out_valid_q | out_ready) & !flush;
    take = in_valid & in_ready;
    ill = take & in_code == ILL_CODE;
    acc = take & !ill;
    state_d = state_q == RUN ? (ill ? TRAP : (acc & in_isBranch) ? BR_WAIT : RUN) :
              state_q == BR_WAIT ? ((br_resolve | flush) ? RUN : BR_WAIT) :
              (trap_clr ? RUN : TRAP);
    out_valid_d = flush ? 1'b0 : acc ? 1'b1 : (out_valid_q & out_ready) ? 1'b0 : out_valid_q;
    fields_d = acc ? {in_rs1i, in_rs2i, in_rdi, in_imm, in_code, in_isLoad, in_isBranch} : fields_q;
    // set wins over a same-cycle writeback; x0 is never tracked
    busy_d = (busy_eff | ((acc & in_isLoad) ? 32'd1 << in_rdi : 32'd0)) & ~32'd1;
    stall_d = (state_q == RUN & hazard & ~&stall_q) ? stall_q + STALL_CNT_W'(1) : stall_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      busy_q      <= '0;
      fields_q    <= '0;
      out_valid_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      fields_q    <= fields_d;
      out_valid_q <= out_valid_d;
      stall_q     <= stall_d;
    end
  end
  assign {out_rs1i, out_rs2i, out_rdi, out_imm, out_code, out_isLoad, out_isBranch} = fields_q;
  assign out_valid = out_valid_q;
  assign trap = state_q == TRAP;
  assign busy_vec = busy_q;
  assign stall_cnt = stall_q;
endmodule
